core_lsu_ctrl: RTL
==================

Name: core_lsu_ctrl

Overview:
- Sequences one data-memory access per load/store instruction over a req/gnt/rvalid bus.
- Stalls the pipeline from issue until the response arrives, then hands back lane-aligned, size-extended load data.
- Sits between the MEM stage and the data-memory port; its load result feeds the writeback mux.
- Detects misaligned accesses and bus timeouts, and flags both as single-cycle error pulses.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MAX_WAIT, 255, cycles spent in REQ+WAIT before the access is declared a bus error.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous assert, active-low
- i_req  in  1  MEM stage holds a valid load/store
- i_we  in  1  1 = store, 0 = load
- i_d_size  in  2  00 byte, 01 half, 1x word
- i_d_unsigned  in  1  zero-extend the load
- i_addr  in  XLEN  byte address
- i_wdata  in  XLEN  store data, right-justified
- i_flush  in  1  kill the in-flight instruction
- o_stall  out  1  freeze the upstream pipeline
- o_data_req  out  1  bus request
- o_data_we  out  1  bus write
- o_data_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- o_data_be  out  4  byte enables
- o_data_wdata  out  XLEN  store data replicated into byte lanes
- i_data_gnt  in  1  request accepted
- i_data_rvalid  in  1  response/ack valid
- i_data_rdata  in  XLEN  read data
- o_rd_data  out  XLEN  aligned, extended load data
- o_rd_valid  out  1  one-cycle completion pulse (loads and stores)
- o_misaligned  out  1  one-cycle error pulse
- o_bus_err  out  1  one-cycle timeout pulse

Behaviour:
- States: IDLE, REQ, WAIT, DONE, ERR, DRAIN.
- Reset: state=IDLE; all outputs and registers 0.
- IDLE:
  - i_req & ~i_flush & aligned: latch we/size/unsigned/addr/wdata, go to REQ.
  - i_req & misaligned: go to ERR; no bus request is issued.
- Misalignment rule: half with addr[0]=1, or word with addr[1:0]≠0.
- REQ:
  - o_data_req=1; addr/we/be/wdata come from the latched fields and stay stable until gnt.
  - i_data_gnt: go to WAIT.
  - i_flush before gnt: drop the request, go to IDLE.
- WAIT:
  - i_data_rvalid: register the aligned data, go to DONE.
  - rvalid is sampled only in WAIT; rvalid in the gnt cycle is not legal on this bus.
  - i_flush in WAIT: go to DRAIN.
- DRAIN:
  - Wait for rvalid, discard the data, go to IDLE.
  - No o_rd_valid is produced; the timeout still applies.
- DONE: o_rd_valid=1 for one cycle, then go to IDLE.
- ERR:
  - Exactly one of o_misaligned / o_bus_err is 1 for one cycle, then go to IDLE.
  - o_rd_data is held at its previous value.
- Timeout:
  - A counter clears on leaving IDLE and increments every cycle in REQ/WAIT/DRAIN.
  - When the count reaches MAX_WAIT-1 with no gnt/rvalid, go to ERR with o_bus_err set (DRAIN goes to IDLE silently).
- o_stall (combinational): (IDLE & i_req & ~i_flush) | REQ | WAIT | DRAIN.
  - Deasserted in DONE and ERR, so the pipeline advances in the same cycle as the pulse.
- Minimum load latency with gnt and rvalid each after 1 cycle: issue cycle (IDLE), REQ, WAIT, DONE, i.e. 3 stall cycles.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- Store data: byte replicated ×4; half replicated ×2.
- Load data:
  - rdata is shifted right by 8×addr[1:0].
  - byte: sign-extend from bit 7 unless unsigned.
  - half: sign-extend from bit 15 unless unsigned.
  - word: passed through unchanged.
- Asynchronous reset mid-access forces IDLE immediately; the bus side must tolerate the abandoned request.

Decomposition:
- core_pkg holds:
  - size localparams SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - lsu_state_t enum;
  - a misalignment check function.
- Sub-module core_lsu_align (purely combinational) covers be/wdata lane generation and rdata shift/extension.
- The controller FSM and the timeout counter stay in core_lsu_ctrl.

Test Plan:
- Load word, addr 0x100, gnt after 1 cycle, rvalid=0xDEADBEEF after 1 cycle → 3 stall cycles, o_rd_valid pulse, o_rd_data=0xDEADBEEF, be=1111.
- Signed load byte, addr 0x103, rdata 0x80FFFFFF → be=1000, o_rd_data=0xFFFFFF80; same access unsigned → 0x00000080.
- Store half, addr 0x202, wdata 0x1234ABCD → o_data_addr=0x200, be=1100, o_data_wdata=0xABCDABCD; o_rd_valid on ack.
- Load word at addr 0x101 → no o_data_req, o_misaligned pulses 1 cycle after issue, stall released.
- Flush in WAIT, then rvalid 4 cycles later → DRAIN, no o_rd_valid, back to IDLE; next request issues normally.
- MAX_WAIT=8, gnt never asserted → o_bus_err pulses once after 8 cycles in REQ; reset asserted mid-WAIT → IDLE and all outputs 0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the load/store unit: access sizes, controller
// states and the alignment rule used at issue time.
package core_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_REQ   = 3'd1,
        LSU_WAIT  = 3'd2,
        LSU_DONE  = 3'd3,
        LSU_ERR   = 3'd4,
        LSU_DRAIN = 3'd5
    } lsu_state_t;

    // Halves must sit on even addresses, words on multiples of four.
    // size[1] set means word (both 10 and 11 encode a word access).
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic m;
        m = 1'b0;
        if (size[1])
            m = (addr_lo != 2'b00);
        else if (size == SZ_HALF)
            m = addr_lo[0];
        return m;
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Byte-lane steering for the data port: store byte enables and lane
// replication, and load shift-down plus sign/zero extension.
module core_lsu_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size_i,
    input  logic [1:0]      addr_lo_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] rshift;

    assign rshift = rdata_i >> {addr_lo_i, 3'b000};

    // Store side: enables shifted to the addressed lane, data copied to every lane it could land in
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: lane already shifted to bit 0, extend from the top bit of the access
    always_comb begin
        rdata_o = rshift;
        case (size_i)
            SZ_BYTE: rdata_o = {{24{~unsigned_i & rshift[7]}}, rshift[7:0]};
            SZ_HALF: rdata_o = {{16{~unsigned_i & rshift[15]}}, rshift[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/core_lsu_ctrl.sv
// Load/store controller: one bus access per MEM-stage instruction, with
// pipeline stall, flush/drain handling, misalignment and timeout errors.
module core_lsu_ctrl
    import core_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req,
    input  logic            i_we,
    input  logic [1:0]      i_d_size,
    input  logic            i_d_unsigned,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_data_req,
    output logic            o_data_we,
    output logic [XLEN-1:0] o_data_addr,
    output logic [3:0]      o_data_be,
    output logic [XLEN-1:0] o_data_wdata,
    input  logic            i_data_gnt,
    input  logic            i_data_rvalid,
    input  logic [XLEN-1:0] i_data_rdata,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_rd_valid,
    output logic            o_misaligned,
    output logic            o_bus_err
);

    // Wide enough to hold MAX_WAIT: a flush on the last WAIT cycle lets DRAIN see one count past the limit
    localparam int CW = $clog2(MAX_WAIT + 1);

    lsu_state_t      state_q, state_d;
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rd_data_q;
    logic            mis_q;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            issue;
    logic            mis;
    logic            timeout;
    logic            busy;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_lanes;
    logic [XLEN-1:0] rdata_al;

    assign issue   = i_req & ~i_flush;
    assign mis     = lsu_misaligned(i_d_size, i_addr[1:0]);
    assign timeout = (cnt_q >= CW'(MAX_WAIT - 1));
    assign busy    = (state_q == LSU_REQ) || (state_q == LSU_WAIT) || (state_q == LSU_DRAIN);
    assign cnt_d   = busy ? cnt_q + CW'(1) : '0;

    core_lsu_align #(.XLEN(XLEN)) u_align (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (i_data_rdata),
        .be_o       (be),
        .wdata_o    (wdata_lanes),
        .rdata_o    (rdata_al)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= LSU_IDLE;
        else          state_q <= state_d;
    end

    // Next state; a completed bus handshake wins over flush, flush wins over timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE:
                if (issue) state_d = mis ? LSU_ERR : LSU_REQ;
            LSU_REQ:
                if (i_data_gnt)   state_d = i_flush ? LSU_DRAIN : LSU_WAIT;
                else if (i_flush) state_d = LSU_IDLE;
                else if (timeout) state_d = LSU_ERR;
            LSU_WAIT:
                if (i_data_rvalid) state_d = i_flush ? LSU_IDLE : LSU_DONE;
                else if (i_flush)  state_d = LSU_DRAIN;
                else if (timeout)  state_d = LSU_ERR;
            LSU_DRAIN:
                if (i_data_rvalid || timeout) state_d = LSU_IDLE;
            LSU_DONE: state_d = LSU_IDLE;
            LSU_ERR:  state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // Access fields latched at issue, load result captured on the response, wait counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mis_q     <= 1'b0;
            rd_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == LSU_IDLE && issue) begin
                we_q    <= i_we;
                size_q  <= i_d_size;
                uns_q   <= i_d_unsigned;
                addr_q  <= i_addr;
                wdata_q <= i_wdata;
                mis_q   <= mis;
            end
            if (state_q == LSU_WAIT && i_data_rvalid && !i_flush)
                rd_data_q <= rdata_al;
        end
    end

    // Outputs; bus fields are driven only while requesting so the port idles at zero
    always_comb begin
        o_stall      = (state_q == LSU_IDLE && issue) || busy;
        o_data_req   = (state_q == LSU_REQ);
        o_data_we    = o_data_req & we_q;
        o_data_addr  = o_data_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
        o_data_be    = o_data_req ? be : 4'b0000;
        o_data_wdata = o_data_req ? wdata_lanes : '0;
        o_rd_data    = rd_data_q;
        o_rd_valid   = (state_q == LSU_DONE);
        o_misaligned = (state_q == LSU_ERR) &  mis_q;
        o_bus_err    = (state_q == LSU_ERR) & ~mis_q;
    end

endmodule
